// File: rtl/camera_pkg.sv
// Shared types and constants for the uDMA camera receive path.
package camera_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSof,
    StCapture,
    StSkip,
    StDone
  } cam_ctrl_state_e;

  // Pixel-format selectors understood by the downstream format/filter datapath.
  localparam logic [2:0] FmtRgb565 = 3'd0;
  localparam logic [2:0] FmtRgb555 = 3'd1;
  localparam logic [2:0] FmtRgb444 = 3'd2;
  localparam logic [2:0] FmtBypass = 3'd4;

  localparam int unsigned DropW = 6;

endpackage

// File: rtl/cam_sync_2ff.sv
// Two-flop level synchroniser with asynchronous active-low reset.
module cam_sync_2ff
  import camera_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] r_sync;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], d_i};
    end
  end

  assign q_o = r_sync[1];

endmodule

// File: rtl/camera_frame_ctrl.sv
// Camera-domain frame sequencer: SOF detection, decimation, N-frame capture,
// window slicing and per-byte strobes for the pixel pipeline.
module camera_frame_ctrl
  import camera_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NFR_W = 8
) (
  input  logic             s_cam_clk_dft,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic             cfg_vsync_pol_i,
  input  logic             cfg_framedrop_en_i,
  input  logic [DropW-1:0] cfg_framedrop_val_i,
  input  logic             cfg_slice_en_i,
  input  logic [CNT_W-1:0] cfg_llx_i,
  input  logic [CNT_W-1:0] cfg_lly_i,
  input  logic [CNT_W-1:0] cfg_urx_i,
  input  logic [CNT_W-1:0] cfg_ury_i,
  input  logic [CNT_W-1:0] cfg_rowlen_i,
  input  logic [NFR_W-1:0] cfg_nframes_i,
  input  logic             cam_vsync_i,
  input  logic             cam_hsync_i,
  input  logic             fifo_ready_i,
  output logic             sample_msb_o,
  output logic             byte_capture_o,
  output logic             pix_fire_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [NFR_W-1:0] frame_cnt_o,
  output logic             ovf_o
);

  cam_ctrl_state_e  r_state;
  logic             r_vs;
  logic [DropW-1:0] r_drop_cnt;
  logic [NFR_W-1:0] r_frame_cnt;
  logic             r_frame_done;
  logic             r_ovf;
  logic             r_sample_msb;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  logic             w_en_s;
  logic             w_vs;
  logic             w_sof;
  logic             w_cap;
  logic             w_active;
  logic             w_adv;
  logic             w_in_win;
  logic [NFR_W-1:0] w_frame_cnt_inc;

  cam_sync_2ff u_en_sync (
    .clk_i  (s_cam_clk_dft),
    .rstn_i (rstn_i),
    .d_i    (cfg_en_i),
    .q_o    (w_en_s)
  );

  assign w_vs            = cam_vsync_i ^ cfg_vsync_pol_i;
  assign w_sof           = w_vs & ~r_vs;
  assign w_cap           = ~cfg_framedrop_en_i | (r_drop_cnt == '0);
  assign w_frame_cnt_inc = r_frame_cnt + NFR_W'(1);
  assign w_active        = (r_state == StCapture) & cam_hsync_i;
  // Counters step on the second (LSB) byte of each pixel.
  assign w_adv           = w_active & ~r_sample_msb;

  always_comb begin
    w_in_win = 1'b1;
    if (cfg_slice_en_i) begin
      w_in_win = (r_row >= cfg_lly_i) && (r_row <= cfg_ury_i) &&
                 (r_col >= cfg_llx_i) && (r_col <= cfg_urx_i);
    end
  end

  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= StIdle;
      r_vs         <= 1'b0;
      r_drop_cnt   <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_vs         <= w_vs;
      r_frame_done <= 1'b0;
      if (!w_en_s) begin
        r_state <= StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            r_state     <= StWaitSof;
            r_frame_cnt <= '0;
            r_ovf       <= 1'b0;
            r_drop_cnt  <= '0;
          end
          StWaitSof, StCapture, StSkip: begin
            if (w_sof) begin
              if (cfg_framedrop_en_i) begin
                r_drop_cnt <= (r_drop_cnt == cfg_framedrop_val_i) ? '0 :
                              r_drop_cnt + DropW'(1);
              end else begin
                r_drop_cnt <= '0;
              end
              if (r_state == StCapture) begin
                r_frame_done <= 1'b1;
                r_frame_cnt  <= w_frame_cnt_inc;
              end
              if ((r_state == StCapture) && (cfg_nframes_i != '0) &&
                  (w_frame_cnt_inc == cfg_nframes_i)) begin
                r_state <= StDone;
              end else begin
                r_state <= w_cap ? StCapture : StSkip;
              end
            end
          end
          StDone: r_state <= StDone;
          default: r_state <= StIdle;
        endcase
      end
      // Placed last so a dropped word is never lost to the re-arm clear.
      if (pix_fire_o && !fifo_ready_i) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sample_msb <= 1'b1;
      r_col        <= '0;
      r_row        <= '0;
    end else begin
      if (!cam_hsync_i || (r_state != StCapture)) begin
        r_sample_msb <= 1'b1;
      end else begin
        r_sample_msb <= ~r_sample_msb;
      end
      if (w_sof) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_adv) begin
        if (r_col == cfg_rowlen_i) begin
          r_col <= '0;
          if (r_row != '1) begin
            r_row <= r_row + CNT_W'(1);
          end
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end
    end
  end

  assign sample_msb_o   = r_sample_msb;
  assign byte_capture_o = w_active & r_sample_msb;
  assign pix_fire_o     = w_adv & w_in_win;
  assign busy_o         = (r_state == StWaitSof) || (r_state == StCapture) ||
                          (r_state == StSkip);
  assign frame_done_o   = r_frame_done;
  assign frame_cnt_o    = r_frame_cnt;
  assign ovf_o          = r_ovf;

endmodule
